// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory arbiter
package dmem_pkg;
  localparam int REG_W = 32;
  typedef enum logic [1:0] {LS_BYTE = 2'b00, LS_HALF = 2'b01, LS_WORD = 2'b10} ls_type_e;
  typedef enum logic {SHARED = 1'b0, B_OWN = 1'b1} arb_state_e;
  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] addr;
    logic [REG_W-1:0] wdata;
    ls_type_e         lstype;
    logic             is_unsigned;
  } mem_req_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester A/B and data_memory signals of the arbiter
interface dmem_arbiter_if #(parameter int REG_WIDTH = 32);
  logic                 a_req, a_we, a_unsigned, a_stall, a_rvalid;
  logic [REG_WIDTH-1:0] a_addr, a_wdata, a_rdata;
  logic [1:0]           a_lstype;
  logic                 b_req, b_we, b_lock, b_gnt, b_rvalid;
  logic [REG_WIDTH-1:0] b_addr, b_wdata, b_rdata;
  logic                 mem_read, mem_write, load_unsigned;
  logic [REG_WIDTH-1:0] mem_addr, mem_write_data, mem_read_data;
  logic [1:0]           load_store_type;
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_lstype, a_unsigned,
    output a_stall, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata, b_lock,
    output b_gnt, b_rvalid, b_rdata,
    output mem_read, mem_write, mem_addr, mem_write_data, load_store_type, load_unsigned,
    input  mem_read_data
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, a_lstype, a_unsigned,
    input  a_stall, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata, b_lock,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_read, mem_write, mem_addr, mem_write_data, load_store_type, load_unsigned,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_starve_counter.sv
// dmem_starve_counter: saturating wait counter flagging when port B must win
module dmem_starve_counter #(parameter int LIMIT = 4) (
  input  logic clk,
  input  logic rstn,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  assign at_limit = cnt == W'(LIMIT);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !at_limit) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: fixed-priority A / lockable B data-memory arbiter; DMEM_ARB_ALIGN_CHECK_EN adds misalign_err
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int REG_WIDTH    = REG_W,
  parameter int NUM_MEM_LOCS = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rstn,
  dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  ,
  output logic           misalign_err
`endif
);
  if (REG_WIDTH != REG_W || NUM_MEM_LOCS < 1) begin : g_bad_cfg
    $error("dmem_arbiter: unsupported configuration");
  end
  arb_state_e state;
  logic at_limit, a_win, b_win, act, mis;
  mem_req_t a_fld, b_fld, sel;
  always_comb begin
    a_fld = '{we: bus.a_we, addr: bus.a_addr, wdata: bus.a_wdata,
              lstype: ls_type_e'(bus.a_lstype), is_unsigned: bus.a_unsigned};
    b_fld = '{we: bus.b_we, addr: bus.b_addr, wdata: bus.b_wdata,
              lstype: LS_WORD, is_unsigned: 1'b0};
    b_win = bus.b_req && (state == B_OWN || !bus.a_req || at_limit);
    a_win = bus.a_req && state == SHARED && !b_win;
    act   = a_win || b_win;
    sel   = a_win ? a_fld : b_win ? b_fld : '0;
  end
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign mis = act && (sel.lstype == LS_HALF ? sel.addr[0] :
                       sel.lstype == LS_WORD ? |sel.addr[1:0] : 1'b0);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) misalign_err <= 1'b0;
    else misalign_err <= mis;
`else
  assign mis = 1'b0;
`endif
  assign bus.mem_read        = act && !sel.we && !mis;
  assign bus.mem_write       = act && sel.we && !mis;
  assign bus.mem_addr        = sel.addr;
  assign bus.mem_write_data  = sel.wdata;
  assign bus.load_store_type = sel.lstype;
  assign bus.load_unsigned   = sel.is_unsigned;
  assign bus.a_stall         = bus.a_req && !a_win;
  assign bus.b_gnt           = b_win;
  dmem_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rstn     (rstn),
    .inc      (bus.b_req && !b_win),
    .clr      (!bus.b_req || b_win),
    .at_limit (at_limit)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state        <= SHARED;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      bus.a_rdata  <= '0;
      bus.b_rdata  <= '0;
    end else begin
      state        <= (state == B_OWN || b_win) && bus.b_lock ? B_OWN : SHARED;
      bus.a_rvalid <= a_win && bus.mem_read;
      bus.b_rvalid <= b_win && bus.mem_read;
      if (a_win && bus.mem_read) bus.a_rdata <= bus.mem_read_data;
      if (b_win && bus.mem_read) bus.b_rdata <= bus.mem_read_data;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter (covers DMEM_ARB_ALIGN_CHECK_EN when defined)
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic misalign_err;
`endif
  dmem_arbiter_if bus ();
  dmem_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    ,
    .misalign_err (misalign_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic idle;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0; bus.a_lstype = 0; bus.a_unsigned = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0; bus.b_lock = 0;
    bus.mem_read_data = 0;
  endtask
  task automatic test_reset;
    idle();
    rstn = 0;
    #1;
    checks++;
    if ({bus.a_rvalid, bus.b_rvalid} !== 2'b00) begin
      errors++; $display("FAIL reset_rvalid got %b want 00", {bus.a_rvalid, bus.b_rvalid});
    end
    checks++;
    if ({bus.a_rdata, bus.b_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata got %h want 0", {bus.a_rdata, bus.b_rdata});
    end
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.mem_addr} !== 34'h0) begin
      errors++; $display("FAIL reset_idle_mem got %h want 0", {bus.mem_read, bus.mem_write, bus.mem_addr});
    end
    @(negedge clk);
    rstn = 1;
  endtask
  task automatic test_a_load;
    @(negedge clk);
    idle();
    bus.a_req = 1; bus.a_addr = 32'h8; bus.a_lstype = 2'b10; bus.a_unsigned = 1;
    bus.mem_read_data = 32'hDEADBEEF;
    #1;
    checks++;
    if ({bus.a_stall, bus.mem_read, bus.mem_write, bus.mem_addr} !== {3'b010, 32'h8}) begin
      errors++; $display("FAIL a_load_comb got %h want %h", {bus.a_stall, bus.mem_read, bus.mem_write, bus.mem_addr}, {3'b010, 32'h8});
    end
    checks++;
    if ({bus.load_store_type, bus.load_unsigned} !== 3'b101) begin
      errors++; $display("FAIL a_load_type got %b want 101", {bus.load_store_type, bus.load_unsigned});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.a_rvalid, bus.a_rdata, bus.b_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL a_load_ret got %h want %h", {bus.a_rvalid, bus.a_rdata, bus.b_rvalid}, {1'b1, 32'hDEADBEEF, 1'b0});
    end
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    checks++;
    if ({bus.a_rvalid, bus.a_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL a_load_hold got %h want %h", {bus.a_rvalid, bus.a_rdata}, {1'b0, 32'hDEADBEEF});
    end
  endtask
  task automatic test_contention;
    logic exp;
    @(negedge clk);
    idle();
    bus.a_req = 1; bus.a_addr = 32'h4; bus.a_lstype = 2'b10;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 32'h20; bus.b_wdata = 32'h5A5A5A5A;
    for (int c = 1; c <= 10; c++) begin
      exp = (c == 5 || c == 10);
      #1;
      checks++;
      if ({bus.b_gnt, bus.a_stall, bus.mem_write} !== {exp, exp, exp}) begin
        errors++; $display("FAIL contention_cycle%0d got %b want %b", c, {bus.b_gnt, bus.a_stall, bus.mem_write}, {exp, exp, exp});
      end
      @(negedge clk);
    end
    idle();
  endtask
  task automatic test_lock_burst;
    @(negedge clk);
    idle();
    bus.b_req = 1; bus.b_we = 1; bus.b_lock = 1; bus.b_addr = 32'h0; bus.b_wdata = 32'h11;
    #1;
    checks++;
    if ({bus.b_gnt, bus.mem_write, bus.mem_addr} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL lock_first got %h want %h", {bus.b_gnt, bus.mem_write, bus.mem_addr}, {2'b11, 32'h0});
    end
    @(negedge clk);
    bus.a_req = 1; bus.a_addr = 32'h40; bus.a_lstype = 2'b10;
    for (int i = 1; i <= 2; i++) begin
      bus.b_addr = i * 4;
      #1;
      checks++;
      if ({bus.a_stall, bus.mem_write, bus.mem_addr} !== {2'b11, 32'(i * 4)}) begin
        errors++; $display("FAIL lock_beat%0d got %h want %h", i, {bus.a_stall, bus.mem_write, bus.mem_addr}, {2'b11, 32'(i * 4)});
      end
      @(negedge clk);
    end
    bus.b_addr = 32'hC; bus.b_lock = 0;
    #1;
    checks++;
    if ({bus.a_stall, bus.b_gnt, bus.mem_write, bus.mem_addr} !== {3'b111, 32'hC}) begin
      errors++; $display("FAIL lock_release got %h want %h", {bus.a_stall, bus.b_gnt, bus.mem_write, bus.mem_addr}, {3'b111, 32'hC});
    end
    @(negedge clk);
    bus.b_req = 0;
    #1;
    checks++;
    if ({bus.a_stall, bus.mem_read, bus.mem_addr} !== {2'b01, 32'h40}) begin
      errors++; $display("FAIL lock_a_resume got %h want %h", {bus.a_stall, bus.mem_read, bus.mem_addr}, {2'b01, 32'h40});
    end
    @(negedge clk);
    idle();
  endtask
  task automatic test_b_read;
    @(negedge clk);
    idle();
    bus.b_req = 1; bus.b_addr = 32'h10; bus.mem_read_data = 32'h12345678;
    #1;
    checks++;
    if ({bus.load_store_type, bus.load_unsigned, bus.mem_read, bus.b_gnt, bus.mem_addr} !== {5'b10011, 32'h10}) begin
      errors++; $display("FAIL b_read_comb got %h want %h", {bus.load_store_type, bus.load_unsigned, bus.mem_read, bus.b_gnt, bus.mem_addr}, {5'b10011, 32'h10});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.b_rvalid, bus.b_rdata, bus.a_rvalid} !== {1'b1, 32'h12345678, 1'b0}) begin
      errors++; $display("FAIL b_read_ret got %h want %h", {bus.b_rvalid, bus.b_rdata, bus.a_rvalid}, {1'b1, 32'h12345678, 1'b0});
    end
    @(negedge clk);
    idle();
  endtask
  task automatic test_reset_mid_burst;
    @(negedge clk);
    idle();
    bus.b_req = 1; bus.b_lock = 1; bus.b_addr = 32'h14; bus.mem_read_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    checks++;
    if (bus.b_rvalid !== 1'b1) begin
      errors++; $display("FAIL burst_pre_rvalid got %b want 1", bus.b_rvalid);
    end
    #1;
    rstn = 0;
    #1;
    checks++;
    if ({bus.b_rvalid, bus.a_rvalid, bus.b_rdata, bus.a_rdata} !== 66'h0) begin
      errors++; $display("FAIL burst_reset got %h want 0", {bus.b_rvalid, bus.a_rvalid, bus.b_rdata, bus.a_rdata});
    end
    @(negedge clk);
    rstn = 1;
    idle();
    bus.b_lock = 1; bus.a_req = 1; bus.a_addr = 32'h8; bus.a_lstype = 2'b10;
    #1;
    checks++;
    if ({bus.a_stall, bus.mem_read} !== 2'b01) begin
      errors++; $display("FAIL burst_shared_after got %b want 01", {bus.a_stall, bus.mem_read});
    end
    @(negedge clk);
    idle();
  endtask
  task automatic test_misalign;
    @(negedge clk);
    idle();
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 32'h2; bus.a_lstype = 2'b01;
    #1;
    checks++;
    if ({bus.a_stall, bus.mem_write} !== 2'b01) begin
      errors++; $display("FAIL half_aligned got %b want 01", {bus.a_stall, bus.mem_write});
    end
    @(negedge clk);
    bus.a_addr = 32'h3;
    #1;
    checks++;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    if ({bus.a_stall, bus.mem_write} !== 2'b00) begin
      errors++; $display("FAIL half_misaligned got %b want 00", {bus.a_stall, bus.mem_write});
    end
`else
    if ({bus.a_stall, bus.mem_write, bus.mem_addr} !== {2'b01, 32'h3}) begin
      errors++; $display("FAIL half_misaligned got %h want %h", {bus.a_stall, bus.mem_write, bus.mem_addr}, {2'b01, 32'h3});
    end
`endif
    @(posedge clk);
    #1;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    checks++;
    if ({misalign_err, bus.a_rvalid} !== 2'b10) begin
      errors++; $display("FAIL misalign_pulse got %b want 10", {misalign_err, bus.a_rvalid});
    end
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++; $display("FAIL misalign_clear got %b want 0", misalign_err);
    end
`endif
    @(negedge clk);
    idle();
  endtask
  initial begin
    test_reset();
    test_a_load();
    test_contention();
    test_lock_burst();
    test_b_read();
    test_reset_mid_burst();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
